// File: rtl/bkram_pkg.sv
// Shared types and constants for the backup-RAM save/load controller.
// Holds the controller state enum, the save-image header words and parameter defaults.
package bkram_pkg;

  localparam int SECTORS_DEF   = 16;
  localparam int FMT_WORDS_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FMT,
    ST_REQ,
    ST_XFER,
    ST_NEXT
  } state_e;

  // Header words stamped at the start of a freshly formatted save image
  localparam logic [15:0] FMT_HDR [0:3] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

endpackage

// File: rtl/bkram_ctrl_if.sv
// Command, HPS sector handshake and RAM port-B control signals of bkram_ctrl.
// The controller uses the slave view; whoever drives commands and the HPS side uses master.
interface bkram_ctrl_if;

  logic        bk_ena;
  logic        load_req;
  logic        save_req;
  logic        format_req;
  logic [1:0]  slot;
  logic        core_wr;
  logic        sd_ack;
  logic        sd_buff_wr;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic [3:0]  ram_sect;
  logic [1:0]  ram_fmt_addr;
  logic [15:0] ram_fmt_data;
  logic        ram_sel_fmt;
  logic        ram_we_b;
  logic        busy;
  logic        loading;
  logic        dirty;
  logic        done;

  modport master (
    output bk_ena, load_req, save_req, format_req, slot, core_wr, sd_ack, sd_buff_wr,
    input  sd_lba, sd_rd, sd_wr, ram_sect, ram_fmt_addr, ram_fmt_data, ram_sel_fmt,
    input  ram_we_b, busy, loading, dirty, done
  );

  modport slave (
    input  bk_ena, load_req, save_req, format_req, slot, core_wr, sd_ack, sd_buff_wr,
    output sd_lba, sd_rd, sd_wr, ram_sect, ram_fmt_addr, ram_fmt_data, ram_sel_fmt,
    output ram_we_b, busy, loading, dirty, done
  );

endinterface

// File: rtl/bkram_ctrl_edge_rise.sv
// Single-bit rising-edge detector with registered history.
// The history register always tracks the input, so after reset a held level reads as no edge.
module edge_rise (
  input  logic clk_sys,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk_sys) begin
    prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q & ~reset;

endmodule

// File: rtl/bkram_ctrl.sv
// Backup-RAM controller: formats the header, or streams one save slot between
// the HPS sector interface and RAM port B, tracking whether the RAM is dirty.
module bkram_ctrl
  import bkram_pkg::*;
#(
  parameter int SECTORS   = SECTORS_DEF,
  parameter int FMT_WORDS = FMT_WORDS_DEF
) (
  input logic        clk_sys,
  input logic        reset,
  bkram_ctrl_if.slave bus
);

  localparam int                   SECT_BITS = $clog2(SECTORS);
  localparam logic [1:0]           FMT_LAST  = 2'(FMT_WORDS - 1);
  localparam logic [SECT_BITS-1:0] SECT_LAST = SECT_BITS'(SECTORS - 1);

  state_e      state_q, state_d;
  logic [31:0] lba_q, lba_d;
  logic [1:0]  fmtCnt_q, fmtCnt_d;
  logic        loading_q, loading_d;
  logic        dirty_q, dirty_d;
  logic        done_q, done_d;
  logic        loadRise, saveRise, fmtRise, ackFall;
  logic        finish, sdRd, sdWr, ramWe, selFmt;

  edge_rise uLoadEdge (.clk_sys(clk_sys), .reset(reset), .d_i(bus.load_req),   .rise_o(loadRise));
  edge_rise uSaveEdge (.clk_sys(clk_sys), .reset(reset), .d_i(bus.save_req),   .rise_o(saveRise));
  edge_rise uFmtEdge  (.clk_sys(clk_sys), .reset(reset), .d_i(bus.format_req), .rise_o(fmtRise));
  edge_rise uAckEdge  (.clk_sys(clk_sys), .reset(reset), .d_i(~bus.sd_ack),    .rise_o(ackFall));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      lba_q     <= '0;
      fmtCnt_q  <= '0;
      loading_q <= 1'b0;
      dirty_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lba_q     <= lba_d;
      fmtCnt_q  <= fmtCnt_d;
      loading_q <= loading_d;
      dirty_q   <= dirty_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lba_d     = lba_q;
    fmtCnt_d  = fmtCnt_q;
    loading_d = loading_q;
    finish    = 1'b0;
    sdRd      = 1'b0;
    sdWr      = 1'b0;
    ramWe     = 1'b0;
    selFmt    = 1'b0;
    unique case (state_q)
      // Format beats load beats save; anything not taken this cycle is dropped
      ST_IDLE: begin
        if (fmtRise) begin
          state_d  = ST_FMT;
          fmtCnt_d = '0;
        end else if ((loadRise || saveRise) && bus.bk_ena && !bus.sd_ack) begin
          lba_d     = 32'(bus.slot) << SECT_BITS;
          loading_d = loadRise;
          state_d   = ST_REQ;
        end
      end
      ST_FMT: begin
        selFmt   = 1'b1;
        ramWe    = 1'b1;
        fmtCnt_d = fmtCnt_q + 2'd1;
        if (fmtCnt_q == FMT_LAST) begin
          state_d = ST_IDLE;
          finish  = 1'b1;
        end
      end
      ST_REQ: begin
        sdRd = loading_q;
        sdWr = ~loading_q;
        if (bus.sd_ack) state_d = ST_XFER;
      end
      ST_XFER: begin
        ramWe = bus.sd_buff_wr & bus.sd_ack & loading_q;
        if (ackFall) begin
          if (lba_q[SECT_BITS-1:0] == SECT_LAST) begin
            state_d   = ST_IDLE;
            loading_d = 1'b0;
            finish    = 1'b1;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        lba_d[SECT_BITS-1:0] = lba_q[SECT_BITS-1:0] + SECT_BITS'(1);
        state_d              = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
    done_d  = finish;
    dirty_d = bus.core_wr | (dirty_q & ~finish);
  end

  assign bus.sd_lba       = lba_q;
  assign bus.sd_rd        = sdRd;
  assign bus.sd_wr        = sdWr;
  assign bus.ram_sect     = lba_q[3:0];
  assign bus.ram_fmt_addr = fmtCnt_q;
  assign bus.ram_fmt_data = FMT_HDR[fmtCnt_q];
  assign bus.ram_sel_fmt  = selFmt;
  assign bus.ram_we_b     = ramWe;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.loading      = loading_q;
  assign bus.dirty        = dirty_q;
  assign bus.done         = done_q;

endmodule
